// File: rtl/data_mem_access_unit.sv
// Sequencer between the memory stage and a word-wide data memory. Turns byte/half/word
// loads and stores into single-cycle memRead/memWrite operations, using read-modify-write
// for sub-word stores, and rejects misaligned requests without touching memory.
module data_mem_access_unit #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  opWrite,
  input  logic [1:0]            size,
  input  logic                  signExt,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           storeData,
  output logic [31:0]           loadData,
  output logic                  busy,
  output logic                  done,
  output logic                  misalign,
  output logic                  memRead,
  output logic                  memWrite,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [31:0]           memWriteData,
  input  logic [31:0]           memReadData
);

  typedef enum logic [2:0] {StIdle, StRead, StWrite, StDone, StErr} state_e;

  state_e state_q, state_d;

  // Latched request
  logic        op_q;
  logic [1:0]  size_q;
  logic        sext_q;
  logic [1:0]  lane_q;
  logic [15:0] sdata_q;

  // Registered outputs
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic                  done_q, done_d;
  logic                  misalign_q, misalign_d;
  logic                  busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           load_q, load_d;

  logic        accept;
  logic        misal_req;
  logic        word_store;
  logic [31:0] merged;
  logic [31:0] extended;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign accept     = (state_q == StIdle) && req;
  assign misal_req  = (size == 2'b11) || ((size == 2'b01) && address[0]) ||
                      ((size == 2'b10) && (address[1:0] != 2'b00));
  assign word_store = opWrite && (size == 2'b10);

  // State register
  always_ff @(posedge Clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          if (misal_req)       state_d = StErr;
          else if (word_store) state_d = StWrite;
          else                 state_d = StRead;
        end
      end
      StRead:  state_d = op_q ? StWrite : StDone;
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Lane extract/merge on the word returned during READ
  always_comb begin
    rd_byte  = memReadData[{lane_q, 3'b000} +: 8];
    rd_half  = memReadData[{lane_q[1], 4'b0000} +: 16];
    merged   = memReadData;
    extended = memReadData;
    case (size_q)
      2'b00: begin
        merged[{lane_q, 3'b000} +: 8] = sdata_q[7:0];
        extended = sext_q ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
      end
      2'b01: begin
        merged[{lane_q[1], 4'b0000} +: 16] = sdata_q;
        extended = sext_q ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
      end
      default: ;
    endcase
  end

  // Output next values; every output is registered so they follow the next state
  always_comb begin
    mem_read_d  = (state_d == StRead);
    mem_write_d = (state_d == StWrite);
    done_d      = (state_d == StDone) || (state_d == StErr);
    misalign_d  = (state_d == StErr);
    busy_d      = (state_d != StIdle);
    mem_addr_d  = mem_addr_q;
    wdata_d     = wdata_q;
    load_d      = load_q;
    if (accept) begin
      mem_addr_d = {2'b00, address[ADDR_WIDTH-1:2]};
      if (word_store && !misal_req) wdata_d = storeData;
    end
    if (state_q == StRead) begin
      if (op_q) wdata_d = merged;
      else      load_d  = extended;
    end
  end

  // Output and request registers
  always_ff @(posedge Clk) begin
    if (reset) begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      wdata_q     <= 32'h0;
      load_q      <= 32'h0;
      op_q        <= 1'b0;
      size_q      <= 2'b00;
      sext_q      <= 1'b0;
      lane_q      <= 2'b00;
      sdata_q     <= 16'h0;
    end else begin
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      done_q      <= done_d;
      misalign_q  <= misalign_d;
      busy_q      <= busy_d;
      mem_addr_q  <= mem_addr_d;
      wdata_q     <= wdata_d;
      load_q      <= load_d;
      if (accept) begin
        op_q    <= opWrite;
        size_q  <= size;
        sext_q  <= signExt;
        lane_q  <= address[1:0];
        sdata_q <= storeData[15:0];
      end
    end
  end

  assign memRead      = mem_read_q;
  assign memWrite     = mem_write_q;
  assign done         = done_q;
  assign misalign     = misalign_q;
  assign busy         = busy_q;
  assign memAddr      = mem_addr_q;
  assign memWriteData = wdata_q;
  assign loadData     = load_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Bench for data_mem_access_unit: word memory model plus a byte-addressed reference memory.
module tb_data_mem_access_unit;

  logic        Clk = 1'b0;
  logic        reset, req, opWrite, signExt;
  logic [1:0]  size;
  logic [31:0] address, storeData, loadData, memAddr, memWriteData, memReadData;
  logic        busy, done, misalign, memRead, memWrite;

  logic [31:0] mem [0:63];
  logic [7:0]  refb [0:255];
  int passed = 0;
  int total  = 0;

  // Observations of one request
  int          o_lat, o_rd, o_wr, o_both, o_rd_cyc, o_wr_cyc;
  logic        o_addr_bad, o_mis, o_busy1;
  logic [31:0] o_wdata, o_ld;

  always #5 Clk = ~Clk;

  data_mem_access_unit #(.ADDR_WIDTH(32)) dut (
    .Clk(Clk), .reset(reset), .req(req), .opWrite(opWrite), .size(size),
    .signExt(signExt), .address(address), .storeData(storeData), .loadData(loadData),
    .busy(busy), .done(done), .misalign(misalign), .memRead(memRead), .memWrite(memWrite),
    .memAddr(memAddr), .memWriteData(memWriteData), .memReadData(memReadData)
  );

  always @(posedge Clk) if (memWrite) mem[memAddr[5:0]] <= memWriteData;
  assign memReadData = memRead ? mem[memAddr[5:0]] : 32'h0;

  function automatic logic [31:0] ref_word(input int wi);
    return {refb[4*wi+3], refb[4*wi+2], refb[4*wi+1], refb[4*wi]};
  endfunction

  function automatic logic [31:0] ref_load(input int a, input logic [1:0] sz, input logic se);
    logic [7:0]  b;
    logic [15:0] h;
    b = refb[a];
    h = {refb[a+1], refb[a]};
    if (sz == 2'b00) return se ? {{24{b[7]}}, b} : {24'h0, b};
    if (sz == 2'b01) return se ? {{16{h[15]}}, h} : {16'h0, h};
    return ref_word(a / 4);
  endfunction

  function automatic bit is_misal(input int a, input logic [1:0] sz);
    return (sz == 2'b11) || (sz == 2'b01 && (a % 2) != 0) || (sz == 2'b10 && (a % 4) != 0);
  endfunction

  task automatic ref_store(input int a, input logic [1:0] sz, input logic [31:0] d);
    int n;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    for (int i = 0; i < n; i++) refb[a+i] = d[8*i +: 8];
  endtask

  task automatic preload(input int wi, input logic [31:0] v);
    mem[wi] = v;
    for (int i = 0; i < 4; i++) refb[4*wi+i] = v[8*i +: 8];
  endtask

  // Issue one request and watch it until done (bounded); hold keeps req high with other data
  task automatic run_req(input logic w, input logic [1:0] sz, input logic se,
                         input logic [31:0] a, input logic [31:0] d, input bit hold);
    @(negedge Clk);
    req = 1'b1; opWrite = w; size = sz; signExt = se; address = a; storeData = d;
    o_lat = -1; o_rd = 0; o_wr = 0; o_both = 0; o_rd_cyc = -1; o_wr_cyc = -1;
    o_addr_bad = 1'b0; o_mis = 1'b0; o_busy1 = 1'b0; o_wdata = 32'h0; o_ld = 32'h0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge Clk);
      if (hold) begin
        req = 1'b1; opWrite = 1'b1; size = 2'b10; address = a ^ 32'h40; storeData = 32'hDEADBEEF;
      end else begin
        req = 1'b0;
      end
      if (c == 1) o_busy1 = busy;
      if (memRead) begin o_rd++; o_rd_cyc = c; end
      if (memWrite) begin o_wr++; o_wr_cyc = c; o_wdata = memWriteData; end
      if (memRead && memWrite) o_both++;
      if (memAddr !== (a >> 2)) o_addr_bad = 1'b1;
      if (done) begin
        o_lat = c; o_mis = misalign; o_ld = loadData; req = 1'b0;
        break;
      end
    end
    req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0;
    repeat (2) @(negedge Clk);
    total++;
    if ({busy, done, misalign, memRead, memWrite} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000", {busy, done, misalign, memRead, memWrite});
    else passed++;
    total++;
    if ({loadData, memAddr, memWriteData} !== 96'h0)
      $display("FAIL reset_data: got %h %h %h want 0", loadData, memAddr, memWriteData);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_directed();
    run_req(1'b1, 2'b10, 1'b0, 32'h1C, 32'hE0000000, 1'b0);
    ref_store(32'h1C, 2'b10, 32'hE0000000);
    total++;
    if (o_lat !== 2 || o_wr_cyc !== 1 || o_rd !== 0 || o_busy1 !== 1'b1)
      $display("FAIL sw_timing: got lat=%0d wr_cyc=%0d rd=%0d busy=%b want 2 1 0 1",
               o_lat, o_wr_cyc, o_rd, o_busy1);
    else passed++;
    total++;
    if (o_wdata !== 32'hE0000000 || o_addr_bad)
      $display("FAIL sw_data: got %h addr_bad=%b want e0000000 0", o_wdata, o_addr_bad);
    else passed++;

    run_req(1'b0, 2'b10, 1'b0, 32'h1C, 32'h0, 1'b0);
    total++;
    if (o_lat !== 2 || o_rd_cyc !== 1 || o_wr !== 0 || o_ld !== 32'hE0000000 || o_addr_bad)
      $display("FAIL lw: got lat=%0d rd_cyc=%0d wr=%0d ld=%h want 2 1 0 e0000000",
               o_lat, o_rd_cyc, o_wr, o_ld);
    else passed++;

    preload(6, 32'hFFFFFFFF);
    run_req(1'b1, 2'b00, 1'b0, 32'h19, 32'h12, 1'b0);
    ref_store(32'h19, 2'b00, 32'h12);
    total++;
    if (o_lat !== 3 || o_rd_cyc !== 1 || o_wr_cyc !== 2 || o_wdata !== 32'hFFFF12FF)
      $display("FAIL sb_rmw: got lat=%0d rd=%0d wr=%0d data=%h want 3 1 2 ffff12ff",
               o_lat, o_rd_cyc, o_wr_cyc, o_wdata);
    else passed++;
    run_req(1'b0, 2'b00, 1'b0, 32'h19, 32'h0, 1'b0);
    total++;
    if (o_ld !== 32'h00000012) $display("FAIL lbu_19: got %h want 00000012", o_ld);
    else passed++;
    run_req(1'b0, 2'b01, 1'b1, 32'h1A, 32'h0, 1'b0);
    total++;
    if (o_ld !== 32'hFFFFFFFF) $display("FAIL lh_1a: got %h want ffffffff", o_ld);
    else passed++;

    preload(8, 32'hAAAAAAAA);
    run_req(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 1'b0);
    total++;
    if (o_ld !== 32'hFFFFFFAA) $display("FAIL lb_20: got %h want ffffffaa", o_ld);
    else passed++;
    run_req(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 1'b0);
    total++;
    if (o_ld !== 32'h000000AA) $display("FAIL lbu_20: got %h want 000000aa", o_ld);
    else passed++;
    run_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 1'b0);
    total++;
    if (o_ld !== 32'h0000AAAA) $display("FAIL lhu_22: got %h want 0000aaaa", o_ld);
    else passed++;
  endtask

  task automatic test_misaligned();
    logic [31:0] prev_ld;
    logic [31:0] a_list [3];
    logic [1:0]  s_list [3];
    logic        w_list [3];
    a_list = '{32'h1D, 32'h1B, 32'h20};
    s_list = '{2'b10, 2'b01, 2'b11};
    w_list = '{1'b1, 1'b0, 1'b0};
    prev_ld = 32'h0000AAAA;
    for (int i = 0; i < 3; i++) begin
      run_req(w_list[i], s_list[i], 1'b1, a_list[i], 32'h55555555, 1'b0);
      total++;
      if (o_lat !== 1 || o_mis !== 1'b1 || o_rd !== 0 || o_wr !== 0 || o_ld !== prev_ld)
        $display("FAIL misal_%0d: got lat=%0d mis=%b rd=%0d wr=%0d ld=%h want 1 1 0 0 %h",
                 i, o_lat, o_mis, o_rd, o_wr, o_ld, prev_ld);
      else passed++;
    end
    total++;
    if (mem[7] !== 32'hE0000000 || mem[6] !== 32'hFFFF12FF || mem[8] !== 32'hAAAAAAAA)
      $display("FAIL misal_mem: got %h %h %h want e0000000 ffff12ff aaaaaaaa",
               mem[7], mem[6], mem[8]);
    else passed++;
  endtask

  task automatic test_random();
    int          a, bad, exp_lat;
    logic [1:0]  sz;
    logic        w, se;
    logic [31:0] d, exp_ld, exp_w, last_ld;
    bit          mis;
    last_ld = 32'h0000AAAA;
    for (int n = 0; n < 60; n++) begin
      a = $urandom_range(0, 255); sz = 2'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1)); se = 1'($urandom_range(0, 1)); d = $urandom;
      if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~((sz == 2'b10) ? 3 : 1);
      mis = is_misal(a, sz);
      exp_ld = mis ? last_ld : (w ? last_ld : ref_load(a, sz, se));
      if (!mis && w) ref_store(a, sz, d);
      exp_w = ref_word(a / 4);
      exp_lat = mis ? 1 : (w && sz != 2'b10) ? 3 : 2;
      run_req(w, sz, se, 32'(a), d, 1'b0);
      total++;
      if (o_lat !== exp_lat || o_mis !== mis || o_both !== 0)
        $display("FAIL rnd_ctl_%0d: got lat=%0d mis=%b both=%0d want %0d %b 0",
                 n, o_lat, o_mis, o_both, exp_lat, mis);
      else passed++;
      total++;
      if (o_ld !== exp_ld) $display("FAIL rnd_ld_%0d: got %h want %h", n, o_ld, exp_ld);
      else passed++;
      if (!mis && w) begin
        total++;
        if (o_wdata !== exp_w || o_wr !== 1 || o_rd !== ((sz == 2'b10) ? 0 : 1) || o_addr_bad)
          $display("FAIL rnd_st_%0d: got %h wr=%0d rd=%0d want %h", n, o_wdata, o_wr, o_rd, exp_w);
        else passed++;
      end else if (!mis) begin
        total++;
        if (o_rd !== 1 || o_wr !== 0 || o_addr_bad)
          $display("FAIL rnd_lcyc_%0d: got rd=%0d wr=%0d want 1 0", n, o_rd, o_wr);
        else passed++;
      end else begin
        total++;
        if (o_rd !== 0 || o_wr !== 0)
          $display("FAIL rnd_mcyc_%0d: got rd=%0d wr=%0d want 0 0", n, o_rd, o_wr);
        else passed++;
      end
      last_ld = exp_ld;
    end
    @(negedge Clk);
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_word(i)) bad++;
    total++;
    if (bad != 0) $display("FAIL rnd_mem: got %0d bad words want 0", bad);
    else passed++;
  endtask

  task automatic test_back_to_back();
    preload(12, 32'h11223344);
    preload(28, 32'h00000000);
    run_req(1'b1, 2'b00, 1'b0, 32'h30, 32'h0000005A, 1'b1);
    ref_store(32'h30, 2'b00, 32'h5A);
    total++;
    if (o_lat !== 3 || o_wr !== 1 || o_wdata !== 32'h1122335A)
      $display("FAIL busy_ign: got lat=%0d wr=%0d data=%h want 3 1 1122335a",
               o_lat, o_wr, o_wdata);
    else passed++;
    run_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b0);
    total++;
    if (o_lat !== 2 || o_ld !== 32'h1122335A)
      $display("FAIL b2b_load: got lat=%0d ld=%h want 2 1122335a", o_lat, o_ld);
    else passed++;
    total++;
    if (mem[28] !== 32'h0) $display("FAIL busy_mem: got %h want 00000000", mem[28]);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int wr_seen, done_seen;
    preload(16, 32'hCAFEF00D);
    @(negedge Clk);
    req = 1'b1; opWrite = 1'b1; size = 2'b00; signExt = 1'b0; address = 32'h41;
    storeData = 32'h77;
    @(negedge Clk);
    req = 1'b0;
    total++;
    if (memRead !== 1'b1) $display("FAIL rmid_read: got %b want 1", memRead);
    else passed++;
    reset = 1'b1;
    @(negedge Clk);
    reset = 1'b0;
    total++;
    if ({busy, done, misalign, memRead, memWrite} !== 5'b0 ||
        {loadData, memAddr, memWriteData} !== 96'h0)
      $display("FAIL rmid_out: got %b %h %h %h want 0", {busy, done, misalign, memRead, memWrite},
               loadData, memAddr, memWriteData);
    else passed++;
    wr_seen = 0; done_seen = 0;
    repeat (5) begin
      @(negedge Clk);
      if (memWrite) wr_seen++;
      if (done) done_seen++;
    end
    total++;
    if (wr_seen != 0 || done_seen != 0 || mem[16] !== 32'hCAFEF00D)
      $display("FAIL rmid_abort: got wr=%0d done=%0d word=%h want 0 0 cafef00d",
               wr_seen, done_seen, mem[16]);
    else passed++;
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; opWrite = 1'b0; size = 2'b00; signExt = 1'b0;
    address = 32'h0; storeData = 32'h0;
    for (int i = 0; i < 64; i++) preload(i, 32'h0);
    test_reset();
    test_directed();
    test_misaligned();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
